mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one 64-bit memory port between the core's instruction-fetch and data-access requesters. It sits between the `ysyx_2022040010` core's fetch and load/store paths and the DPI-backed memory model. Each request is held until granted. The arbiter serialises transactions with one outstanding at a time, routes each response back to its owner, and bounds fetch starvation under data priority.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch waits; the next contested grant goes to fetch.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  64  fetch byte address, 4-byte aligned
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  32  instruction word
- `d_req`  in  1  data request; held with payload until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  64  data byte address
- `d_wdata`  in  64  store data
- `d_sel`  in  8  byte-lane mask
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse: load data valid, or store ack
- `d_rdata`  out  64  load data
- `mem_req`  out  1  memory request, held until `mem_gnt`
- `mem_we`, `mem_addr`[64], `mem_wdata`[64], `mem_sel`[8]  out  registered payload
- `mem_gnt`  in  1  memory accepts the request this cycle
- `mem_rvalid`  in  1  memory response (read data or write ack)
- `mem_rdata`  in  64  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: may grant.
  - ISSUE: `mem_req`=1, waiting for `mem_gnt`.
  - WAIT: waiting for `mem_rvalid`.
- In IDLE, grants are combinational on the current inputs:
  - Only one requester active: that requester is granted.
  - Both active: data is granted, unless `starve_cnt` == `STARVE_MAX`; then fetch is granted.
- On grant, the arbiter latches the payload and owner (plus `if_addr[2]` for a fetch), then moves IDLE→ISSUE.
- A fetch is issued as `mem_we`=0, `mem_sel`=8'hFF, `mem_addr`=`if_addr`, `mem_wdata`=0.
- ISSUE→WAIT on `mem_gnt`. The payload stays stable throughout ISSUE.
- WAIT→IDLE on `mem_rvalid`. `mem_rdata` is captured, and the owner's `x_rvalid` pulses on the following cycle.
- `if_rdata` is `rdata[63:32]` when latched `addr[2]`=1, else `rdata[31:0]`.
- `d_rdata` is the full captured word. For stores `d_rvalid` still pulses, and `d_rdata` holds the captured `mem_rdata` (the value is don't-care).
- `starve_cnt` behaviour:
  - Increments on each data grant made while `if_req`=1, saturating at `STARVE_MAX`.
  - Clears on a fetch grant or any cycle with `if_req`=0.
- `mem_gnt` outside ISSUE and `mem_rvalid` outside WAIT are ignored.

## Timing
- Reset values: state IDLE; `starve_cnt` 0; all outputs 0, including `mem_*` payload and the rdata registers.
- Reset mid-transaction: return to IDLE, drop any pending response, emit no `x_rvalid`. The memory side tolerates the abandoned request.
- Minimum latency, with grant at cycle 0:
  - `mem_req` high from cycle 1.
  - `mem_gnt`@1 gives WAIT from cycle 2.
  - `mem_rvalid`@2 gives `x_rvalid`@3.
- Back-to-back: the `x_rvalid` cycle is an IDLE cycle, so a new grant can occur in it. Peak throughput is one transaction per 3 cycles.
- `if_gnt` and `d_gnt` are never both 1. No grant is made outside IDLE.
- `mem_gnt` and `mem_rvalid` may arrive any number of cycles late. The arbiter waits indefinitely; there is no timeout.

## Structure
- Shared package contents: state enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`), owner encoding (`OWN_IF`=0, `OWN_D`=1), 64-bit address/data width constants. These are reused by the core's LSU.
- The starvation counter and grant logic form a natural sub-module, `arb_grant_sel`: inputs `if_req`, `d_req`, `idle`; outputs `if_gnt`, `d_gnt`.
- The FSM, payload registers and response routing live in the top.

## Test plan
- Lone fetch: `if_addr`=0x8000_0004, memory returns 0x1111_2222_3333_4444 with `mem_gnt`@1 and `mem_rvalid`@2. Required: `if_rvalid`@3 with `if_rdata`=0x1111_2222, and `mem_sel`=0xFF.
- Lone store: `d_addr`=0x8000_0100, `d_wdata`=0xDEAD_BEEF, `d_sel`=0x0F. Required: `mem_we`=1 with an identical payload, `d_rvalid` pulses once, `if_rvalid` stays 0.
- Contention: `if_req` and `d_req` held high continuously with STARVE_MAX=4. Required grant order D,D,D,D,IF,D,D,D,D,IF. No cycle has both grants.
- Slow memory: `mem_gnt` delayed 5 cycles, `mem_rvalid` delayed 7. Required: payload stable through ISSUE, `busy`=1 throughout, exactly one `x_rvalid`.
- Reset in WAIT: `rst`=0 for 1 cycle, then a late `mem_rvalid`. Required: all outputs 0, no `d_rvalid`, and the next request is granted normally.
- Spurious inputs: `mem_rvalid` pulsed in IDLE and `mem_gnt` pulsed in WAIT. Required: no state change and no `x_rvalid`.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter and the core LSU.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Pick the 32-bit instruction half of a 64-bit memory word.
  function automatic logic [31:0] fetch_word(input logic [DATA_W-1:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Fetch/data grant selection with a bounded fetch-starvation counter.
module arb_grant_sel #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (idle) begin
      if (if_req && (!d_req || starve_cnt_q == CNT_MAX)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    // Counts only data grants that bypassed a waiting fetch.
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one memory port, one transaction in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [SEL_W-1:0]  mem_sel,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              addr2_q, addr2_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              if_gnt_w, d_gnt_w;
  logic              idle;

  // Grants are suppressed while reset is asserted so all outputs read 0.
  assign idle = (state_q == ARB_IDLE) && rst;

  arb_grant_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant_sel (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .idle   (idle),
    .if_gnt (if_gnt_w),
    .d_gnt  (d_gnt_w)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr2_d     = addr2_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    busy_d      = busy_q;
    rdata_d     = rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (if_gnt_w) begin
          owner_d     = OWN_IF;
          addr2_d     = if_addr[2];
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_sel_d   = '1;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ARB_ISSUE;
        end else if (d_gnt_w) begin
          owner_d     = OWN_D;
          addr2_d     = 1'b0;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_sel_d   = d_sel;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
          end else begin
            d_rvalid_d = 1'b1;
          end
        end
      end
      default: begin
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      addr2_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr2_q     <= addr2_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign if_gnt    = if_gnt_w;
  assign d_gnt     = d_gnt_w;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = fetch_word(rdata_q, addr2_q);
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel   = mem_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_sel;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_sel;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called in the first ISSUE cycle: gnt now, rvalid next cycle, returns in the x_rvalid cycle.
  task automatic mem_respond(input logic [63:0] rd);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_own [10];
    int   n;
    int   pulses;

    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;

    // Lone fetch
    tick();
    if_req = 1'b1; if_addr = 64'h8000_0004;
    #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    tick();
    if_req = 1'b0;
    chk("f_mem_req", mem_req, 1);
    chk("f_busy", busy, 1);
    chk("f_mem_sel", mem_sel, 64'hFF);
    chk("f_mem_addr", mem_addr, 64'h8000_0004);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_wdata", mem_wdata, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("f_wait_req", mem_req, 0);
    chk("f_wait_busy", busy, 1);
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 64'h1111_2222);
    chk("f_d_rvalid", d_rvalid, 0);
    chk("f_idle", busy, 0);
    tick();
    chk("f_pulse_end", if_rvalid, 0);

    // Lone store
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8000_0100;
    d_wdata = 64'hDEAD_BEEF; d_sel = 8'h0F;
    #1;
    chk("s_d_gnt", d_gnt, 1);
    chk("s_if_gnt", if_gnt, 0);
    tick();
    d_req = 1'b0;
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_addr", mem_addr, 64'h8000_0100);
    chk("s_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("s_mem_sel", mem_sel, 64'h0F);
    mem_respond(64'h0);
    chk("s_d_rvalid", d_rvalid, 1);
    chk("s_if_rvalid", if_rvalid, 0);
    tick();
    chk("s_pulse_end", d_rvalid, 0);

    // Contention with both requesters held high
    if_req = 1'b1; if_addr = 64'h8000_0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_0400; d_wdata = '0; d_sel = 8'hFF;
    #1;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(if_gnt || d_gnt) && n < 16) begin
        tick();
        n++;
      end
      chk($sformatf("c_timeout_%0d", g), (n < 16), 1);
      chk($sformatf("c_both_%0d", g), (if_gnt && d_gnt), 0);
      chk($sformatf("c_order_%0d", g), d_gnt, exp_own[g]);
      tick();
      chk($sformatf("c_nogrant_issue_%0d", g), {if_gnt, d_gnt}, 0);
      mem_respond(64'h0);
      #1;
    end
    if_req = 1'b0; d_req = 1'b0;

    // Slow memory
    tick(); tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_0200; d_wdata = '0; d_sel = 8'hFF;
    #1;
    chk("sl_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sl_issue_%0d", i),
          {mem_req, busy, mem_we, d_rvalid, mem_sel}, {4'b1100, 8'hFF});
      chk($sformatf("sl_addr_%0d", i), mem_addr, 64'h8000_0200);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("sl_wait_%0d", i), {mem_req, busy, d_rvalid, if_rvalid}, 4'b0100);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_5555_CAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("sl_d_rdata", d_rdata, 64'hAAAA_5555_CAFE_F00D);
      pulses += int'(d_rvalid) + int'(if_rvalid);
      tick();
    end
    chk("sl_pulses", pulses, 1);

    // Reset while waiting for the response
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8000_0300; d_wdata = 64'h55; d_sel = 8'hFF;
    #1;
    chk("r_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("r_in_wait", {busy, mem_req}, 2'b10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("r_ctl_zero", {busy, mem_req, mem_we, if_rvalid, d_rvalid}, 0);
    chk("r_addr_zero", mem_addr, 0);
    chk("r_wdata_zero", mem_wdata, 0);
    chk("r_sel_zero", mem_sel, 0);
    chk("r_rdata_zero", d_rdata, 0);
    chk("r_if_rdata_zero", if_rdata, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rvalid = 1'b0;
    chk("r_late_rvalid", {d_rvalid, if_rvalid, busy}, 0);
    chk("r_late_rdata", d_rdata, 0);
    if_req = 1'b1; if_addr = 64'h8000_0008;
    #1;
    chk("r_if_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0;
    chk("r_if_addr", mem_addr, 64'h8000_0008);
    mem_respond(64'h0123_4567_89AB_CDEF);
    chk("r_if_rvalid", if_rvalid, 1);
    chk("r_if_rdata", if_rdata, 64'h89AB_CDEF);

    // Spurious memory handshakes
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("sp_idle_state", {busy, if_rvalid, d_rvalid}, 0);
    chk("sp_idle_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_0500; d_wdata = '0; d_sel = 8'hF0;
    #1;
    chk("sp_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    mem_gnt = 1'b1;
    tick();
    chk("sp_wait", {busy, mem_req}, 2'b10);
    tick();
    mem_gnt = 1'b0;
    chk("sp_gnt_in_wait", {busy, mem_req, d_rvalid}, 3'b100);
    mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_F00D_1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("sp_d_rvalid", d_rvalid, 1);
    chk("sp_d_rdata", d_rdata, 64'h0BAD_F00D_1234_5678);
    tick();
    chk("sp_end", {d_rvalid, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
